// File: rtl/full_subtractor_pipe_pkg.sv
// Shared constants for the registered full subtractor datapath.
package full_subtractor_pipe_pkg;

  localparam logic RstValid   = 1'b0;
  localparam logic RstBout    = 1'b0;
  localparam logic RstDiffBit = 1'b0;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit combinational full subtractor cell: d = a ^ b ^ bin, borrow-out per ripple rule.
module full_subtractor_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic axb;

  always_comb begin
    axb    = a_i ^ b_i;
    d_o    = axb ^ bin_i;
    bout_o = (~a_i & b_i) | (~axb & bin_i);
  end

endmodule

// File: rtl/full_subtractor_pipe.sv
// Registered WIDTH-bit ripple-borrow subtractor: a - b - bin, result one clock later.
module full_subtractor_pipe
  import full_subtractor_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] difference,
  output logic             bout
);

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] diff_d, diff_q;
  logic             bout_d, bout_q;
  logic             valid_q;

  assign br[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a_i    (a[i]),
      .b_i    (b[i]),
      .bin_i  (br[i]),
      .d_o    (diff_d[i]),
      .bout_o (br[i+1])
    );
  end

  assign bout_d = br[WIDTH];

  // Result registers load only on valid, so junk inputs while idle never reach them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= RstValid;
      diff_q  <= {WIDTH{RstDiffBit}};
      bout_q  <= RstBout;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign difference = diff_q;
  assign bout       = bout_q;

endmodule

// File: tb/tb_full_subtractor_pipe.sv
// Scoreboard bench for full_subtractor_pipe at WIDTH=1 (truth table) and WIDTH=8 (arithmetic).
module tb_full_subtractor_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       v1, a1, b1, bi1;
  logic       ov1, d1, bo1;
  logic       v8, bi8;
  logic [7:0] a8, b8, d8;
  logic       ov8, bo8;

  int n_cmp = 0;
  int n_err = 0;
  int n_out8 = 0;

  logic [1:0] q1[$];
  logic [8:0] q8[$];
  logic [1:0] tt[8];

  always #5 clk = ~clk;

  full_subtractor_pipe #(.WIDTH(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (v1),
    .a          (a1),
    .b          (b1),
    .bin        (bi1),
    .out_valid  (ov1),
    .difference (d1),
    .bout       (bo1)
  );

  full_subtractor_pipe #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (v8),
    .a          (a8),
    .b          (b8),
    .bin        (bi8),
    .out_valid  (ov8),
    .difference (d8),
    .bout       (bo8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference borrow from a 9-bit unsigned subtraction, independent of the cell equations.
  task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    logic [8:0] r;
    r  = {1'b0, a} - {1'b0, b} - {8'd0, bi};
    a8 = a; b8 = b; bi8 = bi; v8 = 1'b1;
    q8.push_back(r);
  endtask

  always @(negedge clk) begin
    if (ov1) begin
      if (q1.size() == 0) chk("w1_unexpected_valid", 1, 0);
      else begin
        logic [1:0] e;
        e = q1.pop_front();
        chk("w1_diff", {31'd0, d1}, {31'd0, e[0]});
        chk("w1_bout", {31'd0, bo1}, {31'd0, e[1]});
      end
    end
    if (ov8) begin
      n_out8++;
      if (q8.size() == 0) chk("w8_unexpected_valid", 1, 0);
      else begin
        logic [8:0] e;
        e = q8.pop_front();
        chk("w8_diff", {24'd0, d8}, {24'd0, e[7:0]});
        chk("w8_bout", {31'd0, bo8}, {31'd0, e[8]});
      end
    end
  end

  initial begin
    // {bout, difference} indexed by {a,b,bin}
    tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b10;
    tt[4] = 2'b01; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;

    rst = 1'b1;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
    v8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bi8 = 1'b0;
    cycle();
    cycle();
    chk("rst_ov1", {31'd0, ov1}, 0);
    chk("rst_d1", {31'd0, d1}, 0);
    chk("rst_bo1", {31'd0, bo1}, 0);
    chk("rst_ov8", {31'd0, ov8}, 0);
    chk("rst_d8", {24'd0, d8}, 0);
    chk("rst_bo8", {31'd0, bo8}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      {a1, b1, bi1} = idx;
      v1 = 1'b1;
      q1.push_back(tt[i]);
      cycle();
    end
    v1 = 1'b0;
    cycle();
    cycle();

    // Reset wins over a valid op on the same edge; held 111 result must be cleared.
    rst = 1'b1; v1 = 1'b1; a1 = 1'b0; b1 = 1'b1; bi1 = 1'b0;
    cycle();
    rst = 1'b0; v1 = 1'b0;
    chk("rstpri_ov1", {31'd0, ov1}, 0);
    chk("rstpri_d1", {31'd0, d1}, 0);
    chk("rstpri_bo1", {31'd0, bo1}, 0);
    cycle();
    chk("rstpri_drop_ov1", {31'd0, ov1}, 0);

    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bi1 = 1'b0;
    q1.push_back(2'b01);
    cycle();
    v1 = 1'b0; a1 = 1'bx; b1 = 1'bx; bi1 = 1'bx;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_ov1", {31'd0, ov1}, 0);
      chk("hold_d1", {31'd0, d1}, 1);
      chk("hold_bo1", {31'd0, bo1}, 0);
    end

    push8(8'h00, 8'h01, 1'b0); cycle();
    push8(8'h80, 8'h7F, 1'b1); cycle();
    push8(8'h00, 8'h00, 1'b1); cycle();
    push8(8'hFF, 8'hFF, 1'b1); cycle();
    for (int i = 0; i < 4; i++) begin
      push8(8'($urandom), 8'($urandom), 1'($urandom));
      cycle();
      if (i > 0) chk("b2b_ov8", {31'd0, ov8}, 1);
    end
    v8 = 1'b0;
    cycle();
    cycle();

    chk("w1_queue_drained", q1.size(), 0);
    chk("w8_queue_drained", q8.size(), 0);
    chk("w8_result_count", n_out8, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
